// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: collects one frame of complex samples arriving in
// bit-reversed order and replays it in natural order while the next frame fills.
module fft_bitrev_reorder #(
  parameter int LOG2N = 3,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_real,
  input  logic signed [WIDTH-1:0] din_imag,
  output logic                    dout_valid,
  output logic signed [WIDTH-1:0] dout_real,
  output logic signed [WIDTH-1:0] dout_imag,
  output logic                    dout_sof,
  output logic                    dout_eof
);

  localparam int N = 2 ** LOG2N;

  typedef logic [LOG2N-1:0] idx_t;

  localparam idx_t IDX_LAST = '1;
  localparam idx_t IDX_ONE  = idx_t'(1);

  logic [2*WIDTH-1:0] mem [2*N];

  idx_t               wr_cnt;
  idx_t               rd_cnt;
  logic               wr_bank;
  logic               rd_bank;
  logic               rd_active;
  logic               frame_done;
  logic [2*WIDTH-1:0] rd_word;

  function automatic idx_t bitrev(input idx_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  assign frame_done = din_valid && (wr_cnt == IDX_LAST);
  assign rd_word    = mem[{rd_bank, rd_cnt}];

  // Write stage: scatter each sample to its natural-order slot in the fill bank
  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem[{wr_bank, bitrev(wr_cnt)}] <= {din_real, din_imag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (din_valid) begin
      wr_cnt <= wr_cnt + IDX_ONE;
      if (wr_cnt == IDX_LAST) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Read stage: sequential replay of the completed bank onto the output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_active  <= 1'b0;
      rd_cnt     <= '0;
      rd_bank    <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      dout_real  <= '0;
      dout_imag  <= '0;
    end else begin
      dout_valid <= rd_active;
      dout_sof   <= rd_active && (rd_cnt == '0);
      dout_eof   <= rd_active && (rd_cnt == IDX_LAST);
      if (rd_active) begin
        dout_real <= $signed(rd_word[2*WIDTH-1:WIDTH]);
        dout_imag <= $signed(rd_word[WIDTH-1:0]);
        rd_cnt    <= rd_cnt + IDX_ONE;
        if (rd_cnt == IDX_LAST) begin
          rd_active <= 1'b0;
        end
      end
      // A frame finishing on the same edge as the last readout restarts without a bubble
      if (frame_done) begin
        rd_active <= 1'b1;
        rd_cnt    <= '0;
        rd_bank   <= wr_bank;
      end
    end
  end

endmodule
